// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO stage: default geometry,
// pointer/count types for that geometry, and a constant log2 helper.
package fifo_pkg;

    localparam int WIDTH      = 4;
    localparam int DEPTH_LOG2 = 2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    // Ceiling log2, at least 1 so a 1-entry array still gets an address bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Depth x Width register array: one synchronous write port, one
// combinational read port. Contents are never reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int Width = WIDTH,
    parameter int Depth = 1 << DEPTH_LOG2,
    parameter int AddrW = clog2(Depth)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_stage.sv
// Show-ahead synchronous FIFO with valid/ready on both sides.
// Flags decode from the count register so full/empty never depend on
// pointer comparison; pointers simply wrap modulo Depth.
module sync_fifo_stage
    import fifo_pkg::*;
#(
    parameter int Width     = WIDTH,
    parameter int DepthLog2 = DEPTH_LOG2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [Width-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [Width-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DepthLog2:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam int Depth = 1 << DepthLog2;
    localparam logic [DepthLog2:0]   CntFull = (DepthLog2 + 1)'(Depth);
    localparam logic [DepthLog2:0]   CntOne  = (DepthLog2 + 1)'(1);
    localparam logic [DepthLog2-1:0] PtrOne  = DepthLog2'(1);

    logic [DepthLog2-1:0] wr_ptr;
    logic [DepthLog2-1:0] rd_ptr;
    logic [DepthLog2:0]   cnt_q;
    logic [Width-1:0]     rdata;
    logic                 push;
    logic                 pop;

    assign full      = (cnt_q == CntFull);
    assign empty     = (cnt_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = cnt_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // Mask the stale array word so an empty FIFO presents zero.
    assign out_data  = empty ? '0 : rdata;

    // Pointer and occupancy update; reset wins over any handshake.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrOne;
            if (pop)  rd_ptr <= rd_ptr + PtrOne;
            if (push && !pop)      cnt_q <= cnt_q + CntOne;
            else if (pop && !push) cnt_q <= cnt_q - CntOne;
        end
    end

    fifo_mem #(
        .Width (Width),
        .Depth (Depth),
        .AddrW (DepthLog2)
    ) u_mem (
        .CLK   (CLK),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo_stage.sv
// Scoreboard bench for sync_fifo_stage (Width=4, Depth=4).
// Stimulus drives inputs 1 time unit after each posedge, checks the
// registered state 3 units later and queues accepted words; the monitor
// on negedge pops the queue for every word the consumer takes.
module tb_sync_fifo_stage;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int total = 0;
    int bad   = 0;
    bit started = 0;
    logic [3:0] q[$];

    sync_fifo_stage #(.Width(4), .DepthLog2(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check the state left by the last edge,
    // then record what the coming edge should accept.
    task automatic step(input logic rst, input logic v, input logic [3:0] d, input logic r);
        int n;
        @(posedge CLK);
        #1;
        RST = rst; in_valid = v; in_data = d; out_ready = r;
        #3;
        if (started) begin
            n = q.size();
            chk("count",     32'(count),     32'(n));
            chk("empty",     32'(empty),     32'(n == 0));
            chk("full",      32'(full),      32'(n == 4));
            chk("in_ready",  32'(in_ready),  32'(n != 4));
            chk("out_valid", 32'(out_valid), 32'(n != 0));
            chk("out_data",  32'(out_data),  (n != 0) ? 32'(q[0]) : 32'h0);
        end
        if (!rst) begin
            q.delete();
            started = 1;
        end else if (v && q.size() < 4) begin
            q.push_back(d);
        end
    endtask

    // Every word the consumer takes must be the oldest outstanding one.
    always @(negedge CLK) begin
        if (RST === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h expected no word", out_data);
            end else begin
                chk("pop_data", 32'(out_data), 32'(q[0]));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges with a write request pending.
        step(1'b0, 1'b1, 4'h9, 1'b0);
        step(1'b0, 1'b1, 4'h9, 1'b0);
        // Fill to four entries, then try a fifth.
        step(1'b1, 1'b1, 4'h1, 1'b0);
        step(1'b1, 1'b1, 4'h2, 1'b0);
        step(1'b1, 1'b1, 4'h3, 1'b0);
        step(1'b1, 1'b1, 4'h4, 1'b0);
        step(1'b1, 1'b1, 4'h5, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        // Drain from full.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        // Prime to two entries, then push and pop together past the wrap.
        step(1'b1, 1'b1, 4'h1, 1'b0);
        step(1'b1, 1'b1, 4'h2, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'(3 + i), 1'b1);
        // Third entry, then reset mid-operation with both handshakes active.
        step(1'b1, 1'b1, 4'hD, 1'b0);
        step(1'b0, 1'b1, 4'h7, 1'b1);
        step(1'b1, 1'b1, 4'hA, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            logic v, r;
            logic [3:0] d;
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = 4'($urandom_range(0, 15));
            step(1'b1, v, d, r);
        end
        // Drain whatever is left and confirm it empties.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
